// File: rtl/wide_bram_port.sv
// -----------------------------------------------------------------------------
// wide_bram_port
//
// Presents a wide memory of ADDRS words, each PIECES*BRAM_WIDTH bits, on top of
// a narrow external BRAM. Each wide word is spread over PIECES consecutive BRAM
// locations. Piece k of word A lives at BRAM address A*PIECES+k, and piece 0
// holds the least significant bits.
//
// A write sequences one piece per cycle to the BRAM. The per-piece mask gates
// bram_we for each piece. write_done pulses for one cycle when the write ends.
//
// A read issues one BRAM address per cycle with no gaps. Each returning piece is
// collected READ_LATENCY cycles after its address was sampled. The assembled
// word is then held on resp_data until the consumer takes it.
//
// An out-of-range request keeps the normal cycle timing but does not touch the
// BRAM. A read of such an address returns zero data with resp_err set.
//
// Parameters
//   ADDRS        number of wide words
//   BRAM_WIDTH   BRAM data width
//   PIECES       BRAM words per wide word
//   READ_LATENCY BRAM address-to-dout cycles (1..3)
//
// Ports
//   clk_in, rst_in          clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_write               1 = write, 0 = read
//   req_addr                wide-word address
//   req_data, req_mask      write data and per-piece write enable
//   resp_valid/resp_ready   read response handshake
//   resp_data, resp_err     read data, out-of-range flag
//   write_done              one-cycle pulse at write completion
//   bram_addr, bram_din     BRAM address and write data
//   bram_we, bram_regce     BRAM write enable and output register enable
//   bram_dout               BRAM read data
// -----------------------------------------------------------------------------
module wide_bram_port #(
    parameter int ADDRS        = 1024,
    parameter int BRAM_WIDTH   = 64,
    parameter int PIECES       = 32,
    parameter int READ_LATENCY = 2,
    parameter int WIDTH        = PIECES * BRAM_WIDTH,
    parameter int AW           = $clog2(ADDRS),
    parameter int BAW          = $clog2(ADDRS * PIECES)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AW-1:0]         req_addr,
    input  logic [WIDTH-1:0]      req_data,
    input  logic [PIECES-1:0]     req_mask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  resp_err,
    output logic                  write_done,
    output logic [BAW-1:0]        bram_addr,
    output logic [BRAM_WIDTH-1:0] bram_din,
    output logic                  bram_we,
    output logic                  bram_regce,
    input  logic [BRAM_WIDTH-1:0] bram_dout
);

    // The counter reaches PIECES+READ_LATENCY-1 during a read.
    localparam int CW = $clog2(PIECES + READ_LATENCY + 1);
    localparam logic [CW-1:0] LAST_PIECE = CW'(PIECES - 1);
    localparam logic [CW-1:0] RD_LAT     = CW'(READ_LATENCY);
    localparam logic [CW-1:0] LAST_READ  = CW'(PIECES + READ_LATENCY - 1);
    localparam logic [AW:0]   ADDRS_C    = (AW + 1)'(ADDRS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0]         r_cnt;
    logic                  r_in_range;
    logic                  r_err;
    logic [WIDTH-1:0]      r_wdata;
    logic [PIECES-1:0]     r_mask;
    logic [WIDTH-1:0]      r_resp_data;
    logic                  r_write_done;
    logic [BAW-1:0]        r_bram_addr;
    logic [BRAM_WIDTH-1:0] r_bram_din;
    logic                  r_bram_we;
    logic                  r_bram_regce;

    logic                  w_in_range;
    logic [BAW-1:0]        w_base;
    logic [WIDTH-1:0]      w_dout_top;

    // The base address is computed at full BRAM address width. This lets the
    // top word reach ADDRS*PIECES-1 without truncation.
    assign w_in_range = ({1'b0, req_addr} < ADDRS_C);
    assign w_base     = BAW'(req_addr) * BAW'(PIECES);

    // Incoming pieces enter at the top of the response register and shift down.
    // After PIECES captures, piece 0 sits in the least significant slot.
    assign w_dout_top = WIDTH'(bram_dout) << (WIDTH - BRAM_WIDTH);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_next = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (r_cnt == LAST_PIECE) begin
                    w_state_next = IDLE;
                end
            end
            READ: begin
                if (r_cnt == LAST_READ) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    // r_cnt equals k after edge Ek, where E0 is the acceptance edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt        <= '0;
            r_in_range   <= 1'b0;
            r_err        <= 1'b0;
            r_wdata      <= '0;
            r_mask       <= '0;
            r_resp_data  <= '0;
            r_write_done <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_din   <= '0;
            r_bram_we    <= 1'b0;
            r_bram_regce <= 1'b0;
        end else begin
            r_write_done <= 1'b0;
            r_bram_we    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_cnt      <= '0;
                        r_in_range <= w_in_range;
                        // An out-of-range request leaves the BRAM address alone.
                        if (w_in_range) begin
                            r_bram_addr <= w_base;
                        end
                        if (req_write) begin
                            r_bram_din   <= req_data[BRAM_WIDTH-1:0];
                            r_wdata      <= req_data >> BRAM_WIDTH;
                            r_mask       <= req_mask >> 1;
                            r_bram_we    <= req_mask[0] & w_in_range;
                            r_bram_regce <= 1'b0;
                        end else begin
                            r_resp_data  <= '0;
                            r_err        <= ~w_in_range;
                            r_bram_regce <= w_in_range;
                        end
                    end
                end
                WRITE: begin
                    if (r_cnt == LAST_PIECE) begin
                        r_write_done <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt + CW'(1);
                        r_bram_din <= r_wdata[BRAM_WIDTH-1:0];
                        r_wdata    <= r_wdata >> BRAM_WIDTH;
                        r_mask     <= r_mask >> 1;
                        r_bram_we  <= r_mask[0] & r_in_range;
                        if (r_in_range) begin
                            r_bram_addr <= r_bram_addr + BAW'(1);
                        end
                    end
                end
                READ: begin
                    r_cnt <= r_cnt + CW'(1);
                    // Keep issuing addresses until the last piece is out.
                    // Then hold the final address while the pipeline drains.
                    if (r_in_range && (r_cnt < LAST_PIECE)) begin
                        r_bram_addr <= r_bram_addr + BAW'(1);
                    end
                    // Piece (r_cnt - READ_LATENCY) is on bram_dout now.
                    if (r_in_range && (r_cnt >= RD_LAT)) begin
                        r_resp_data <= (r_resp_data >> BRAM_WIDTH) | w_dout_top;
                    end
                    if (r_cnt == LAST_READ) begin
                        r_bram_regce <= 1'b0;
                    end
                end
                RESP: begin
                    r_bram_regce <= 1'b0;
                end
                default: begin
                    r_bram_regce <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_err   = r_err & resp_valid;
    assign resp_data  = r_resp_data;
    assign write_done = r_write_done;
    assign bram_addr  = r_bram_addr;
    assign bram_din   = r_bram_din;
    assign bram_we    = r_bram_we;
    assign bram_regce = r_bram_regce;

endmodule
